// File: rtl/rs_encode_req_arbiter_if.sv
// Bus bundle between clients, the shared RS encoder and the request arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface rs_encode_req_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned META_W  = 64
);
    logic [NUM_REQ-1:0]        src_arb_req_val;
    logic [NUM_REQ-1:0]        arb_src_req_rdy;
    logic [NUM_REQ*META_W-1:0] src_arb_req_meta;

    logic [NUM_REQ-1:0]        src_arb_data_val;
    logic [NUM_REQ-1:0]        arb_src_data_rdy;
    logic [NUM_REQ*DATA_W-1:0] src_arb_data;

    logic                      arb_enc_req_val;
    logic                      enc_arb_req_rdy;
    logic [META_W-1:0]         arb_enc_req_meta;

    logic                      arb_enc_data_val;
    logic                      enc_arb_data_rdy;
    logic [DATA_W-1:0]         arb_enc_data;

    logic                      enc_arb_resp_val;
    logic                      arb_enc_resp_rdy;
    logic [DATA_W-1:0]         enc_arb_resp_data;
    logic                      enc_arb_resp_last;

    logic [NUM_REQ-1:0]        arb_dst_resp_val;
    logic [NUM_REQ-1:0]        dst_arb_resp_rdy;
    logic [DATA_W-1:0]         arb_dst_resp_data;
    logic                      arb_dst_resp_last;

    modport master (
        input  src_arb_req_val, src_arb_req_meta, src_arb_data_val, src_arb_data,
        input  enc_arb_req_rdy, enc_arb_data_rdy,
        input  enc_arb_resp_val, enc_arb_resp_data, enc_arb_resp_last, dst_arb_resp_rdy,
        output arb_src_req_rdy, arb_src_data_rdy,
        output arb_enc_req_val, arb_enc_req_meta, arb_enc_data_val, arb_enc_data,
        output arb_enc_resp_rdy, arb_dst_resp_val, arb_dst_resp_data, arb_dst_resp_last
    );

    modport slave (
        output src_arb_req_val, src_arb_req_meta, src_arb_data_val, src_arb_data,
        output enc_arb_req_rdy, enc_arb_data_rdy,
        output enc_arb_resp_val, enc_arb_resp_data, enc_arb_resp_last, dst_arb_resp_rdy,
        input  arb_src_req_rdy, arb_src_data_rdy,
        input  arb_enc_req_val, arb_enc_req_meta, arb_enc_data_val, arb_enc_data,
        input  arb_enc_resp_rdy, arb_dst_resp_val, arb_dst_resp_data, arb_dst_resp_last
    );
endinterface

// File: rtl/rs_encode_req_arbiter.sv
// Round-robin arbiter sharing one RS stream encoder among NUM_REQ clients.
// Grant is held from metadata through the final parity line; data paths are pure muxes.
module rs_encode_req_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned DATA_W  = 256,
    parameter  int unsigned META_W  = 64,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    rs_encode_req_arbiter_if.master bus,
    output logic                  arb_busy,
    output logic [ID_W-1:0]       arb_grant_id
);
    localparam int unsigned IDX_W = ID_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        META   = 2'd1,
        STREAM = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   win_c;
    logic [IDX_W-1:0]  idx;
    logic              found;
    logic              last_hs_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_c = rr_ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'(rr_ptr_q) + IDX_W'(i);
            if (idx >= IDX_W'(NUM_REQ)) idx = idx - IDX_W'(NUM_REQ);
            if (!found && bus.src_arb_req_val[ID_W'(idx)]) begin
                found = 1'b1;
                win_c = ID_W'(idx);
            end
        end
    end

    assign last_hs_c = bus.enc_arb_resp_val && bus.dst_arb_resp_rdy[grant_q]
                       && bus.enc_arb_resp_last;

    always_comb begin
        state_d                = state_q;
        grant_d                = grant_q;
        rr_ptr_d               = rr_ptr_q;
        arb_busy               = (state_q != IDLE);
        bus.arb_src_req_rdy    = '0;
        bus.arb_src_data_rdy   = '0;
        bus.arb_enc_req_val    = 1'b0;
        bus.arb_enc_req_meta   = '0;
        bus.arb_enc_data_val   = 1'b0;
        bus.arb_enc_data       = '0;
        bus.arb_enc_resp_rdy   = 1'b0;
        bus.arb_dst_resp_val   = '0;
        bus.arb_dst_resp_data  = bus.enc_arb_resp_data;
        bus.arb_dst_resp_last  = bus.enc_arb_resp_last;

        case (state_q)
            IDLE: begin
                if (|bus.src_arb_req_val) begin
                    grant_d = win_c;
                    state_d = META;
                end
            end
            META: begin
                bus.arb_enc_req_val           = 1'b1;
                bus.arb_enc_req_meta          = bus.src_arb_req_meta[32'(grant_q)*META_W +: META_W];
                bus.arb_src_req_rdy[grant_q]  = bus.enc_arb_req_rdy;
                if (bus.enc_arb_req_rdy) state_d = STREAM;
            end
            STREAM: begin
                bus.arb_enc_data_val          = bus.src_arb_data_val[grant_q];
                bus.arb_enc_data              = bus.src_arb_data[32'(grant_q)*DATA_W +: DATA_W];
                bus.arb_src_data_rdy[grant_q] = bus.enc_arb_data_rdy;
                bus.arb_dst_resp_val[grant_q] = bus.enc_arb_resp_val;
                bus.arb_enc_resp_rdy          = bus.dst_arb_resp_rdy[grant_q];
                if (last_hs_c) begin
                    rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d                = state_e'('x);
                arb_busy               = 1'bx;
                bus.arb_src_req_rdy    = 'x;
                bus.arb_src_data_rdy   = 'x;
                bus.arb_enc_req_val    = 1'bx;
                bus.arb_enc_req_meta   = 'x;
                bus.arb_enc_data_val   = 1'bx;
                bus.arb_enc_data       = 'x;
                bus.arb_enc_resp_rdy   = 1'bx;
                bus.arb_dst_resp_val   = 'x;
                bus.arb_dst_resp_data  = 'x;
                bus.arb_dst_resp_last  = 1'bx;
            end
        endcase
    end

    assign arb_grant_id = grant_q;

endmodule

// File: doc/rs_encode_req_arbiter.md
# rs_encode_req_arbiter

Round-robin arbiter that shares one Reed-Solomon stream encoder among `NUM_REQ` independent clients. Each client issues a metadata request, then streams data lines. The arbiter grants one client at a time and forwards its metadata and data to the encoder. It routes the encoder's output stream (data lines followed by parity lines) back to that client only. The grant is held until the final output line is accepted, so encoder jobs never interleave.

## Interface
Parameters:
- `NUM_REQ`, 4, number of clients (2..16)
- `DATA_W`, 256, data/parity line width
- `META_W`, 64, request metadata width (opaque to this block)
- `ID_W`, `$clog2(NUM_REQ)`, derived; not overridden

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `src_arb_req_val` in NUM_REQ / `arb_src_req_rdy` out NUM_REQ / `src_arb_req_meta` in NUM_REQ*META_W: per-client metadata request; client i occupies slice i.
- `src_arb_data_val` in NUM_REQ / `arb_src_data_rdy` out NUM_REQ / `src_arb_data` in NUM_REQ*DATA_W: per-client data lines.
- `arb_enc_req_val` out 1 / `enc_arb_req_rdy` in 1 / `arb_enc_req_meta` out META_W: metadata to the encoder.
- `arb_enc_data_val` out 1 / `enc_arb_data_rdy` in 1 / `arb_enc_data` out DATA_W: data lines to the encoder.
- `enc_arb_resp_val` in 1 / `arb_enc_resp_rdy` out 1 / `enc_arb_resp_data` in DATA_W / `enc_arb_resp_last` in 1: encoder output; `last` marks the final parity line.
- `arb_dst_resp_val` out NUM_REQ / `dst_arb_resp_rdy` in NUM_REQ / `arb_dst_resp_data` out DATA_W / `arb_dst_resp_last` out 1: output to clients. Data and last are broadcast; val is one-hot.
- `arb_busy` out 1: state is not IDLE.
- `arb_grant_id` out ID_W: registered grant index.

## Operation
- Handshake: a transfer occurs when val & rdy. Senders hold val and payload stable until the transfer completes.
- State machine:
  - IDLE:
    - Outputs: all rdy and val outputs are 0.
    - Transition: if any `src_arb_req_val` is set, register the winner into `grant_reg` and go to META.
  - META:
    - Outputs: `arb_enc_req_val`=1; `arb_enc_req_meta` = slice `grant_reg`; `arb_src_req_rdy[grant_reg]` = `enc_arb_req_rdy`.
    - Transition: on the encoder handshake, go to STREAM.
  - STREAM:
    - Data path: `arb_enc_data_val` = `src_arb_data_val[grant_reg]`; `arb_enc_data` = slice `grant_reg`; `arb_src_data_rdy[grant_reg]` = `enc_arb_data_rdy`.
    - Response path: `arb_dst_resp_val[grant_reg]` = `enc_arb_resp_val`; `arb_enc_resp_rdy` = `dst_arb_resp_rdy[grant_reg]`.
    - Transition: on a response handshake with `enc_arb_resp_last`=1, set `rr_ptr` = (`grant_reg`+1) mod NUM_REQ and go to IDLE.
- Winner selection: the first set bit of `src_arb_req_val`, scanning from `rr_ptr` upward and wrapping at NUM_REQ.
  - `rr_ptr` wraps from NUM_REQ-1 to 0.
  - For non-power-of-2 NUM_REQ, indices ≥ NUM_REQ are never produced.
- Non-granted clients see rdy=0 and val=0 on every port, at all times.
- Data and response streams overlap freely in STREAM. Data lines still pending from the client when `last` arrives are a protocol error; they are not drained.
- Response beats in IDLE or META are not accepted (`arb_enc_resp_rdy`=0).
- Unused/invalid state encoding: drive all outputs to X and next state to X.

## Timing
- Reset values, asynchronous and immediate:
  - state=IDLE, `grant_reg`=0, `rr_ptr`=0.
  - All val/rdy outputs 0; `arb_busy`=0; `arb_grant_id`=0.
- Reset mid-job aborts immediately with no drain. The encoder must be reset with the same `rst`.
- Arbitration latency:
  - A request seen in IDLE at cycle N gives `arb_enc_req_val`=1 at cycle N+1.
  - The earliest meta transfer is at N+1.
- Data and response paths: zero latency, purely combinational muxes. No registers in the data path.
- Job turnaround: the last response handshake at cycle M returns to IDLE at M+1. The next grant's META is at M+2, a one-cycle bubble.
- Simultaneous requests are resolved by round-robin only. A request arriving during a job waits; the current job is never preempted.
- `arb_grant_id` changes only on the IDLE→META transition.

## Test plan
- Single client 2, `rr_ptr`=0:
  - Grant goes to 2.
  - Metadata 0xABCD reaches `arb_enc_req_meta`.
  - 3 data lines pass through.
  - 5 response lines (last on the 5th) arrive only on `arb_dst_resp_val[2]`.
  - Then `rr_ptr`=3 and `arb_busy`=0 at M+1.
- All 4 clients request together after reset: grant order 0,1,2,3,0 across five jobs, with one idle cycle between jobs.
- Clients 1 and 3 request with `rr_ptr`=2: client 3 is served first, then client 1.
- Backpressure: hold `dst_arb_resp_rdy[1]`=0 for 10 cycles mid-response.
  - `arb_enc_resp_rdy`=0 throughout.
  - No beat is lost or duplicated.
  - State stays STREAM.
- Non-granted isolation: client 0 holds data val high while client 1 is granted. `arb_src_data_rdy[0]` stays 0 and client 0's data never appears on `arb_enc_data`.
- Assert `rst` during STREAM after 2 response beats:
  - All outputs are 0 in the same cycle.
  - State is IDLE and `rr_ptr`=0.
  - A new request is granted normally after reset deasserts.
